// File: rtl/player_hit_ctl_pkg.sv
// Shared game definitions for the player damage path and the sprite draw stages.
//   hit_state_t : player damage FSM state encoding (2 bits)
//   PLAYER_W/H  : default player sprite box size, px
//   MISSILE_W/H : default enemy missile box size, px
//   COORD_W     : screen coordinate width
package player_hit_ctl_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } hit_state_t;

    localparam int PLAYER_W  = 64;
    localparam int PLAYER_H  = 48;
    localparam int MISSILE_W = 4;
    localparam int MISSILE_H = 12;
    localparam int COORD_W   = 11;

endpackage

// File: rtl/box_overlap.sv
// Combinational rectangle intersect test between box A and box B.
// Edges are extended to 12 bits before adding the sizes so a box near
// x/y = 2047 never wraps around to the left/top of the screen.
// Boxes that only touch (no shared pixel) do not overlap.
//   xa, ya   : box A left/top edge
//   xb, yb   : box B left/top edge
//   overlap  : 1 when the two boxes share at least one pixel
module box_overlap #(
    parameter int A_W = 64,
    parameter int A_H = 48,
    parameter int B_W = 4,
    parameter int B_H = 12
) (
    input  logic [10:0] xa,
    input  logic [10:0] ya,
    input  logic [10:0] xb,
    input  logic [10:0] yb,
    output logic        overlap
);

    logic [11:0] xa_l, ya_t, xb_l, yb_t;
    logic [11:0] xa_r, ya_b, xb_r, yb_b;

    always_comb begin
        xa_l = {1'b0, xa};
        ya_t = {1'b0, ya};
        xb_l = {1'b0, xb};
        yb_t = {1'b0, yb};
        xa_r = xa_l + 12'(A_W);
        ya_b = ya_t + 12'(A_H);
        xb_r = xb_l + 12'(B_W);
        yb_b = yb_t + 12'(B_H);
        overlap = (xb_l < xa_r) && (xa_l < xb_r) &&
                  (yb_t < ya_b) && (ya_t < yb_b);
    end

endmodule

// File: rtl/player_hit_ctl.sv
// Player damage controller. Once per frame (rising edge of vblnk_in) the
// active enemy missile is tested against the player box. A hit costs a life
// and opens an invulnerability window during which the sprite blinks; losing
// the last life latches game_over until restart.
//   pclk            : pixel clock
//   rst             : asynchronous active-low reset
//   vblnk_in        : vertical blank, rising edge = frame tick
//   xpos/ypos_player: player box left/top edge
//   x/ypos_missile_en, on_missile_en : enemy missile box and valid
//   restart         : one-cycle pulse, new game (wins over a same-cycle tick)
//   lives_out       : remaining lives
//   player_on       : player sprite visible this frame
//   hit_out         : one-cycle pulse per registered hit
//   game_over       : set once lives reach 0
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ALIVE  | vulnerable, sprite always drawn
// ST_INVULN | hits ignored for INV_FRAMES ticks, sprite blinks
// ST_DEAD   | no lives left, sprite hidden, waits for restart
module player_hit_ctl #(
    parameter int LIVES        = 3,
    parameter int PLAYER_W     = player_hit_ctl_pkg::PLAYER_W,
    parameter int PLAYER_H     = player_hit_ctl_pkg::PLAYER_H,
    parameter int MISSILE_W    = player_hit_ctl_pkg::MISSILE_W,
    parameter int MISSILE_H    = player_hit_ctl_pkg::MISSILE_H,
    parameter int INV_FRAMES   = 120,
    parameter int BLINK_FRAMES = 8
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [10:0] xpos_player,
    input  logic [10:0] ypos_player,
    input  logic [10:0] xpos_missile_en,
    input  logic [10:0] ypos_missile_en,
    input  logic        on_missile_en,
    input  logic        restart,
    output logic [2:0]  lives_out,
    output logic        player_on,
    output logic        hit_out,
    output logic        game_over
);

    import player_hit_ctl_pkg::*;

    localparam logic [2:0] LIVES_LOAD = 3'(LIVES);
    localparam logic [7:0] INV_LOAD   = 8'(INV_FRAMES);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    hit_state_t state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] inv_cnt_q, inv_cnt_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_ph_q, blink_ph_d;
    logic       hit_q, hit_d;
    logic       game_over_q, game_over_d;
    logic       player_on_q, player_on_d;
    logic       vblnk_d;
    logic       tick;
    logic       box_hit;
    logic       hit_now;

    box_overlap #(
        .A_W (PLAYER_W),
        .A_H (PLAYER_H),
        .B_W (MISSILE_W),
        .B_H (MISSILE_H)
    ) u_box_overlap (
        .xa      (xpos_player),
        .ya      (ypos_player),
        .xb      (xpos_missile_en),
        .yb      (ypos_missile_en),
        .overlap (box_hit)
    );

    assign tick    = vblnk_in & ~vblnk_d;
    assign hit_now = on_missile_en & box_hit;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ALIVE;
            lives_q     <= LIVES_LOAD;
            inv_cnt_q   <= 8'd0;
            blink_cnt_q <= 8'd0;
            blink_ph_q  <= 1'b0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
            player_on_q <= 1'b1;
            vblnk_d     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            inv_cnt_q   <= inv_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            hit_q       <= hit_d;
            game_over_q <= game_over_d;
            player_on_q <= player_on_d;
            vblnk_d     <= vblnk_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        inv_cnt_d   = inv_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        hit_d       = 1'b0;
        game_over_d = game_over_q;
        player_on_d = player_on_q;

        if (restart) begin
            state_d     = ST_ALIVE;
            lives_d     = LIVES_LOAD;
            inv_cnt_d   = 8'd0;
            blink_cnt_d = 8'd0;
            blink_ph_d  = 1'b0;
            game_over_d = 1'b0;
            player_on_d = 1'b1;
        end else if (tick) begin
            case (state_q)
                ST_ALIVE: begin
                    if (hit_now) begin
                        hit_d = 1'b1;
                        if (lives_q > 3'd1) begin
                            lives_d     = lives_q - 3'd1;
                            inv_cnt_d   = INV_LOAD;
                            blink_cnt_d = 8'd0;
                            blink_ph_d  = 1'b0;
                            player_on_d = 1'b1;
                            state_d     = ST_INVULN;
                        end else begin
                            lives_d     = 3'd0;
                            game_over_d = 1'b1;
                            player_on_d = 1'b0;
                            state_d     = ST_DEAD;
                        end
                    end
                end
                ST_INVULN: begin
                    // inv_cnt is a down-counter; terminal count 1 ends the window.
                    if (inv_cnt_q == 8'd1) begin
                        inv_cnt_d   = 8'd0;
                        blink_cnt_d = 8'd0;
                        blink_ph_d  = 1'b0;
                        player_on_d = 1'b1;
                        state_d     = ST_ALIVE;
                    end else begin
                        inv_cnt_d = inv_cnt_q - 8'd1;
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_d = 8'd0;
                            blink_ph_d  = ~blink_ph_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 8'd1;
                        end
                        player_on_d = ~blink_ph_d;
                    end
                end
                ST_DEAD: begin
                    player_on_d = 1'b0;
                    game_over_d = 1'b1;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end
    end

    assign lives_out = lives_q;
    assign player_on = player_on_q;
    assign hit_out   = hit_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_player_hit_ctl.sv
module tb_player_hit_ctl;

    localparam int PW = 64, PH = 48, MW = 4, MH = 12;
    localparam int INV = 120, BLK = 8, NLIVES = 3;

    typedef struct packed {
        logic [2:0] hits;
        logic [2:0] lives;
        logic       po;
        logic       go;
    } obs_t;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        on_missile_en = 1'b0;
    logic        restart = 1'b0;
    logic [10:0] xpos_player = 11'd0, ypos_player = 11'd0;
    logic [10:0] xpos_missile_en = 11'd0, ypos_missile_en = 11'd0;
    logic [2:0]  lives_out;
    logic        player_on, hit_out, game_over;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: lives left, dead flag, ticks of protection left,
    // ticks elapsed since protection started
    int m_lives, m_inv_left, m_inv_age;
    bit m_dead;

    player_hit_ctl dut (
        .pclk            (pclk),
        .rst             (rst),
        .vblnk_in        (vblnk_in),
        .xpos_player     (xpos_player),
        .ypos_player     (ypos_player),
        .xpos_missile_en (xpos_missile_en),
        .ypos_missile_en (ypos_missile_en),
        .on_missile_en   (on_missile_en),
        .restart         (restart),
        .lives_out       (lives_out),
        .player_on       (player_on),
        .hit_out         (hit_out),
        .game_over       (game_over)
    );

    always #5 pclk = ~pclk;

    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

    // two boxes share a pixel when the intersection of their spans is non-empty
    function automatic bit m_overlap(int xp, int yp, int xm, int ym, bit on);
        int x_lo, x_hi, y_lo, y_hi;
        x_lo = imax(xp, xm);  x_hi = imin(xp + PW, xm + MW);
        y_lo = imax(yp, ym);  y_hi = imin(yp + PH, ym + MH);
        return on && (x_lo < x_hi) && (y_lo < y_hi);
    endfunction

    task automatic model_reset();
        m_lives = NLIVES; m_dead = 0; m_inv_left = 0; m_inv_age = 0;
    endtask

    task automatic model_tick(input bit ov, output bit hit);
        hit = 0;
        if (m_dead) return;
        if (m_inv_left > 0) begin
            m_inv_left--; m_inv_age++;
            return;
        end
        if (ov) begin
            hit = 1;
            m_lives--;
            if (m_lives == 0) m_dead = 1;
            else begin m_inv_left = INV; m_inv_age = 0; end
        end
    endtask

    function automatic obs_t model_expect(bit hit);
        obs_t e;
        e.hits  = hit ? 3'd1 : 3'd0;
        e.lives = 3'(m_lives);
        e.po    = m_dead ? 1'b0 : (m_inv_left > 0) ? (((m_inv_age / BLK) % 2) == 0) : 1'b1;
        e.go    = m_dead;
        return e;
    endfunction

    // one video frame: vblnk high for 3 cycles, low for 2; returns what the DUT
    // showed one cycle after the tick plus the number of hit_out cycles
    task automatic do_frame(input int xp, input int yp, input int xm, input int ym,
                            input bit on, input bit rs, output obs_t o, output obs_t e);
        bit eh;
        @(negedge pclk);
        xpos_player = 11'(xp); ypos_player = 11'(yp);
        xpos_missile_en = 11'(xm); ypos_missile_en = 11'(ym);
        on_missile_en = on; restart = rs; vblnk_in = 1'b1;
        @(posedge pclk); #1;
        restart = 1'b0;
        o.hits = 3'(hit_out); o.lives = lives_out; o.po = player_on; o.go = game_over;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin @(negedge pclk); vblnk_in = 1'b0; end
            @(posedge pclk); #1;
            o.hits = o.hits + 3'(hit_out);
        end
        if (rs) begin model_reset(); eh = 0; end
        else model_tick(m_overlap(xp, yp, xm, ym, on), eh);
        e = model_expect(eh);
    endtask

    task automatic do_restart();
        @(negedge pclk); restart = 1'b1;
        @(posedge pclk); #1; restart = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        obs_t o, e;
        rst = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        o = {3'(hit_out), lives_out, player_on, game_over};
        e = {3'd0, 3'd3, 1'b1, 1'b0};
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_hold: got %h want %h", o, e); end
        @(negedge pclk); rst = 1'b1;
        model_reset();
        @(posedge pclk); #1;
        o = {3'(hit_out), lives_out, player_on, game_over};
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_release: got %h want %h", o, e); end
    endtask

    task automatic test_no_hit();
        obs_t o, e;
        do_frame(400, 500, 100, 100, 1, 0, o, e);
        n_cmp++;
        if (o !== e || o.hits != 0 || o.lives != 3) begin
            n_bad++; $display("FAIL no_hit: got %h want %h", o, e);
        end
    endtask

    task automatic test_hit_invuln();
        obs_t o, e;
        do_frame(400, 500, 420, 510, 1, 0, o, e);
        n_cmp++;
        if (o !== e || o.hits != 1 || o.lives != 2) begin
            n_bad++; $display("FAIL first_hit: got %h want %h", o, e);
        end
        for (int i = 1; i <= INV; i++) begin
            do_frame(400, 500, 420, 510, 1, 0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++; $display("FAIL invuln tick %0d: got %h want %h", i, o, e);
            end
        end
        do_frame(400, 500, 420, 510, 1, 0, o, e);
        n_cmp++;
        if (o !== e || o.lives != 1 || o.hits != 1) begin
            n_bad++; $display("FAIL hit_after_invuln: got %h want %h", o, e);
        end
    endtask

    task automatic test_touch_edge();
        int tbl [8][3] = '{'{464, 510, 0}, '{463, 510, 1}, '{396, 510, 0}, '{397, 510, 1},
                           '{420, 548, 0}, '{420, 547, 1}, '{420, 488, 0}, '{420, 489, 1}};
        obs_t o, e;
        for (int i = 0; i < 8; i++) begin
            do_restart();
            do_frame(400, 500, tbl[i][0], tbl[i][1], 1, 0, o, e);
            n_cmp++;
            if (o !== e || int'(o.hits) != tbl[i][2]) begin
                n_bad++;
                $display("FAIL edge (%0d,%0d): got %h want %h hit %0d",
                         tbl[i][0], tbl[i][1], o, e, tbl[i][2]);
            end
        end
    endtask

    task automatic test_game_over();
        obs_t o, e;
        do_restart();
        for (int h = 0; h < 3; h++) begin
            do_frame(400, 500, 420, 510, 1, 0, o, e);
            n_cmp++;
            if (o !== e || o.hits != 1) begin
                n_bad++; $display("FAIL go_hit %0d: got %h want %h", h, o, e);
            end
            if (h < 2) begin
                for (int i = 0; i < INV; i++) begin
                    do_frame(400, 500, 420, 510, 0, 0, o, e);
                    n_cmp++;
                    if (o !== e) begin
                        n_bad++; $display("FAIL go_wait %0d/%0d: got %h want %h", h, i, o, e);
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_frame(400, 500, 420, 510, 1, 0, o, e);
            n_cmp++;
            if (o !== e || o !== obs_t'({3'd0, 3'd0, 1'b0, 1'b1})) begin
                n_bad++; $display("FAIL dead_frame %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_restart();
        obs_t o, e;
        // from DEAD, restart coincides with an overlapping tick
        do_frame(400, 500, 420, 510, 1, 1, o, e);
        n_cmp++;
        if (o !== e || o !== obs_t'({3'd0, 3'd3, 1'b1, 1'b0})) begin
            n_bad++; $display("FAIL restart_dead: got %h want %h", o, e);
        end
        // from ALIVE, the hit on the restart tick is discarded
        do_frame(400, 500, 420, 510, 1, 1, o, e);
        n_cmp++;
        if (o !== e || o !== obs_t'({3'd0, 3'd3, 1'b1, 1'b0})) begin
            n_bad++; $display("FAIL restart_alive: got %h want %h", o, e);
        end
        // still vulnerable afterwards
        do_frame(400, 500, 420, 510, 1, 0, o, e);
        n_cmp++;
        if (o !== e || o.hits != 1 || o.lives != 2) begin
            n_bad++; $display("FAIL after_restart_hit: got %h want %h", o, e);
        end
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        do_restart();
        do_frame(400, 500, 420, 510, 1, 0, o, e);
        for (int i = 0; i < 12; i++) do_frame(400, 500, 420, 510, 1, 0, o, e);
        @(posedge pclk); #3;
        rst = 1'b0;
        #1;
        o = {3'(hit_out), lives_out, player_on, game_over};
        e = {3'd0, 3'd3, 1'b1, 1'b0};
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL async_reset: got %h want %h", o, e); end
        @(negedge pclk); rst = 1'b1;
        model_reset();
        do_frame(400, 500, 420, 510, 1, 0, o, e);
        n_cmp++;
        if (o !== e || o.lives != 2) begin
            n_bad++; $display("FAIL post_reset_hit: got %h want %h", o, e);
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        int xp, yp, xm, ym;
        bit on, rs;
        do_restart();
        for (int i = 0; i < 400; i++) begin
            xp = int'($urandom_range(0, 2047));
            yp = int'($urandom_range(0, 2047));
            xm = imin(2047, imax(0, xp + int'($urandom_range(0, 160)) - 80));
            ym = imin(2047, imax(0, yp + int'($urandom_range(0, 160)) - 80));
            if ($urandom_range(0, 15) == 0) xm = int'($urandom_range(0, 2047));
            on = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 29) == 0);
            do_frame(xp, yp, xm, ym, on, rs, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL random %0d p(%0d,%0d) m(%0d,%0d) on=%0d rs=%0d: got %h want %h",
                         i, xp, yp, xm, ym, on, rs, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_hit();
        test_hit_invuln();
        test_touch_edge();
        test_game_over();
        test_restart();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/player_hit_ctl.md
# player_hit_ctl

Player-side damage controller fed by the enemy stage's missile position outputs. Once per video frame it checks the active enemy missile against the player's sprite box. A hit decrements the player's life count and starts an invulnerability window, during which the player sprite blinks. When the last life is lost it latches game-over. Outputs drive the player draw stage, the HUD and the top-level game controller.

## Interface
- `LIVES`, default 3: lives after reset or restart (1..7).
- `PLAYER_W`, default 64: player box width, px.
- `PLAYER_H`, default 48: player box height, px.
- `MISSILE_W`, default 4: enemy missile width, px.
- `MISSILE_H`, default 12: enemy missile height, px.
- `INV_FRAMES`, default 120: invulnerability length, frames (1..255).
- `BLINK_FRAMES`, default 8: frames per blink half-period (1..INV_FRAMES).

Ports:
- `pclk` in 1: pixel clock, the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `vblnk_in` in 1: vertical blank; its rising edge is the frame tick.
- `xpos_player` in 11: player box left edge.
- `ypos_player` in 11: player box top edge.
- `xpos_missile_en` in 11: enemy missile left edge.
- `ypos_missile_en` in 11: enemy missile top edge.
- `on_missile_en` in 1: enemy missile active.
- `restart` in 1: single-cycle pulse that starts a new game.
- `lives_out` out 3: remaining lives.
- `player_on` out 1: player sprite is drawn this frame (blink-gated).
- `hit_out` out 1: one-cycle pulse when a hit is registered.
- `game_over` out 1: level flag, set once lives reach 0.

## Operation
- Frame tick: `vblnk_d` registers `vblnk_in`. The tick is `vblnk_in & ~vblnk_d`.
- All positions are sampled only at the tick. Between ticks the outputs and state hold.
- Overlap test uses 12-bit zero-extended sums, so there is no wrap at 2047. A hit requires all five conditions:
  - `on_missile_en` = 1
  - xm < xp+PLAYER_W
  - xp < xm+MISSILE_W
  - ym < yp+PLAYER_H
  - yp < ym+MISSILE_H
- Edges touching exactly, with no shared pixel, are not a hit.
- States:
  - ALIVE: on a tick with a hit and `lives_out` > 1, decrement lives, pulse `hit_out`, load `inv_cnt` with INV_FRAMES and go to INVULN. On a tick with a hit and `lives_out` = 1, set lives to 0, pulse `hit_out`, set `game_over` and go to DEAD.
  - INVULN: overlap is ignored and `hit_out` never pulses. Each tick decrements `inv_cnt`. On the tick where `inv_cnt` = 1, go to ALIVE.
  - DEAD: `player_on` = 0, `game_over` = 1, no hit detection.
- Blink, INVULN only:
  - `blink_cnt` counts ticks modulo BLINK_FRAMES. `blink_ph` toggles at each wrap.
  - Both are cleared on entry to INVULN.
  - `player_on` = ~`blink_ph`, so the first BLINK_FRAMES frames are visible.
  - In ALIVE, `player_on` = 1.
- Restart: `restart` = 1 in any state loads LIVES, goes to ALIVE, clears all counters and clears `game_over`. Restart has priority over a tick in the same cycle, and the hit on that tick is discarded.

## Timing
- Reset values: state ALIVE, `lives_out` = LIVES, `player_on` = 1, `hit_out` = 0, `game_over` = 0, all counters 0, `vblnk_d` = 0.
- Latency: outputs are registered. They update on the same `pclk` edge that samples the tick, so they are valid 1 cycle after `vblnk_in` rises.
- `hit_out` is high for exactly 1 `pclk` cycle per hit.
- `vblnk_in` held high gives one tick only.
- Reset asserted mid-invulnerability returns all outputs to their reset values immediately (asynchronous). Operation resumes on the first edge after release.

## Structure
- Shared game package holds:
  - state encoding `ST_ALIVE`, `ST_INVULN`, `ST_DEAD` (2 bits)
  - default sprite sizes `PLAYER_W`, `PLAYER_H`, `MISSILE_W`, `MISSILE_H`, shared with the draw stages
- One sub-module, `box_overlap`: combinational 12-bit rectangle intersect, reused by the enemy collision logic.
- FSM, frame-tick edge detector and counters stay in the top module.

## Test plan
- Reset, then one tick with missile at (100,100), player at (400,500) -> `lives_out` = 3, `hit_out` never asserts, `player_on` = 1.
- Missile at (420,510), on = 1, player at (400,500), one tick -> `hit_out` 1-cycle pulse, `lives_out` = 2, INVULN. With defaults (INV_FRAMES 120, BLINK_FRAMES 8): `player_on` is 1 for frames 1-8, 0 for 9-16, and the player is ALIVE again after tick 120.
- Same overlap held for 120 ticks from the INVULN entry -> no further decrement. The next tick in ALIVE decrements to 1.
- Touching edge, missile x = 464 (xp+PLAYER_W) -> no hit. Missile x = 463 -> hit.
- Three separated hits -> `lives_out` = 0, `game_over` = 1, `player_on` = 0. Further overlap -> no `hit_out`.
- `restart` in the same cycle as a hitting tick, and also while in DEAD -> `lives_out` = 3, ALIVE, `game_over` = 0, no `hit_out`. Assert `rst` low mid-INVULN -> outputs return to reset values before the next `pclk` edge.
